// File: rtl/ptosda_param.sv
// ptosda_param: WIDTH-bit parallel-to-serial framer emitting START, data bits and STOP on scl/sda.
// Define PTOSDA_PARITY_EN to insert an even-parity slot between the data bits and STOP.
module ptosda_param #(
  parameter int WIDTH     = 8,
  parameter int HALF_DIV  = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             data_valid,
  output logic             ack,
  output logic             busy,
  output logic             scl,
  output logic             sda,
  output logic             frame_done
);

  localparam int PW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_BITS   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef PTOSDA_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [2:0]       r_state;
  logic [PW-1:0]    r_phase;
  logic [1:0]       r_half;
  logic [BW-1:0]    r_bit;
  logic [WIDTH-1:0] r_shift;
  logic             r_ack;
  logic             r_busy;
  logic             r_scl;
  logic             r_sda;
  logic             r_done;
`ifdef PTOSDA_PARITY_EN
  logic             r_parity;
`endif

  logic             w_phaseEnd;
  logic             w_lastBit;
  logic             w_outBit;
  logic [WIDTH-1:0] w_shiftNext;

  assign w_phaseEnd  = (r_phase == PW'(HALF_DIV - 1));
  assign w_lastBit   = (r_bit == BW'(WIDTH - 1));
  assign w_outBit    = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
  assign w_shiftNext = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

  assign ack        = r_ack;
  assign busy       = r_busy;
  assign scl        = r_scl;
  assign sda        = r_sda;
  assign frame_done = r_done;

  // Each non-idle state is a sequence of half-slots of HALF_DIV cycles; r_half indexes them.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_half  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_scl   <= 1'b1;
      r_sda   <= 1'b1;
      r_done  <= 1'b0;
`ifdef PTOSDA_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_phase <= '0;
      end else begin
        r_phase <= w_phaseEnd ? '0 : r_phase + PW'(1);
      end

      case (r_state)
        S_IDLE: begin
          r_half <= '0;
          r_bit  <= '0;
          r_scl  <= 1'b1;
          r_sda  <= 1'b1;
          if (data_valid) begin
            r_shift <= data;
`ifdef PTOSDA_PARITY_EN
            r_parity <= ^data;
`endif
            r_ack   <= 1'b1;
            r_busy  <= 1'b1;
            r_sda   <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_phaseEnd) begin
            if (r_half == 2'd0) begin
              r_half <= 2'd1;
              r_scl  <= 1'b0;
            end else begin
              r_half  <= 2'd0;
              r_sda   <= w_outBit;
              r_shift <= w_shiftNext;
              r_state <= S_BITS;
            end
          end
        end

        // sda only moves at slot boundaries, where scl is being driven low.
        S_BITS: begin
          if (w_phaseEnd) begin
            if (r_half == 2'd0) begin
              r_half <= 2'd1;
              r_scl  <= 1'b1;
            end else begin
              r_half <= 2'd0;
              r_scl  <= 1'b0;
              if (w_lastBit) begin
                r_bit <= '0;
`ifdef PTOSDA_PARITY_EN
                r_sda   <= r_parity;
                r_state <= S_PARITY;
`else
                r_sda   <= 1'b0;
                r_state <= S_STOP;
`endif
              end else begin
                r_bit   <= r_bit + BW'(1);
                r_sda   <= w_outBit;
                r_shift <= w_shiftNext;
              end
            end
          end
        end

`ifdef PTOSDA_PARITY_EN
        S_PARITY: begin
          if (w_phaseEnd) begin
            if (r_half == 2'd0) begin
              r_half <= 2'd1;
              r_scl  <= 1'b1;
            end else begin
              r_half  <= 2'd0;
              r_scl   <= 1'b0;
              r_sda   <= 1'b0;
              r_state <= S_STOP;
            end
          end
        end
`endif

        S_STOP: begin
          if (w_phaseEnd) begin
            if (r_half == 2'd0) begin
              r_half <= 2'd1;
              r_scl  <= 1'b1;
            end else if (r_half == 2'd1) begin
              r_half <= 2'd2;
              r_sda  <= 1'b1;
            end else begin
              r_half  <= 2'd0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
